// File: rtl/dither_tx_pkg.sv
// Shared types and constants for the dithered-image return path.
// Contents:
//   tx_state_t   - transmit FSM state encoding
//   PIX_PER_BYTE - thresholded pixels packed into one bus byte
package dither_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    ACCUM   = 3'd3,
    PRESENT = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } tx_state_t;

  localparam int unsigned PIX_PER_BYTE = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving from another clock domain.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset (clears both stages)
//   d    - asynchronous input
//   q    - synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dither_image_tx.sv
// Streams the processed frame from the result SRAM to the MCU over an 8-bit
// parallel bus with a 4-phase valid/ack handshake. Optionally packs eight
// thresholded pixels (MSB of each) per byte, first pixel in bit 7.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   start        - 1-cycle pulse: frame ready in SRAM (ignored unless idle)
//   ram_rd_addr  - SRAM read address
//   ram_rd_en    - SRAM read strobe; data returns one cycle later
//   ram_rd_data  - SRAM read data
//   mcu_ack      - MCU acknowledge, asynchronous to clk
//   tx_data      - byte to MCU, stable while tx_valid is high
//   tx_valid     - byte presented
//   busy         - high from start acceptance until the done cycle
//   done         - 1-cycle pulse after the last byte's handshake
module dither_image_tx
  import dither_tx_pkg::*;
#(
  parameter int IMAGEX           = 16,
  parameter int IMAGEY           = 16,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter bit PACK_BITS        = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                        ram_rd_en,
  input  logic [RGB_SIZE-1:0]         ram_rd_data,
  input  logic                        mcu_ack,
  output logic [RGB_SIZE-1:0]         tx_data,
  output logic                        tx_valid,
  output logic                        busy,
  output logic                        done
);

  // One extra bit so the terminal count IMAGE_SIZE is representable.
  localparam logic [IMAGE_ADDR_WIDTH:0] PIX_TOTAL = (IMAGE_ADDR_WIDTH + 1)'(IMAGE_SIZE);
  localparam logic [2:0]                BIT_LAST  = 3'(PIX_PER_BYTE - 1);

  tx_state_t                   state;
  tx_state_t                   next_state;
  logic [IMAGE_ADDR_WIDTH:0]   pix_cnt;
  logic [2:0]                  bit_cnt;
  logic                        ack_s;

  sync_2ff #(.WIDTH(1)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (mcu_ack),
    .q   (ack_s)
  );

  assign ram_rd_addr = pix_cnt[IMAGE_ADDR_WIDTH-1:0];

  // Next-state logic for the read / pack / handshake sequence.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) next_state = RD_REQ;
        else       next_state = IDLE;
      end
      RD_REQ:  next_state = RD_WAIT;
      RD_WAIT: next_state = ACCUM;
      ACCUM: begin
        // Raw mode presents every pixel; packed mode only after the 8th.
        if (!PACK_BITS || (bit_cnt == BIT_LAST)) next_state = PRESENT;
        else                                      next_state = RD_REQ;
      end
      PRESENT: begin
        if (ack_s) next_state = RELEASE;
        else       next_state = PRESENT;
      end
      RELEASE: begin
        if (ack_s)                        next_state = RELEASE;
        else if (pix_cnt == PIX_TOTAL)    next_state = DONE;
        else                              next_state = RD_REQ;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus outputs registered from the upcoming state, so each
  // output is glitch-free and aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_rd_en <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      ram_rd_en <= (next_state == RD_REQ);
      tx_valid  <= (next_state == PRESENT);
      busy      <= (next_state inside {RD_REQ, RD_WAIT, ACCUM, PRESENT, RELEASE});
      done      <= (next_state == DONE);
    end
  end

  // Pixel/bit counters and the outgoing byte (doubles as the pack shifter).
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
      bit_cnt <= 3'd0;
      tx_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pix_cnt <= '0;
            bit_cnt <= 3'd0;
          end
        end
        ACCUM: begin
          // SRAM output is still holding the word read in RD_REQ.
          pix_cnt <= pix_cnt + 1'b1;
          if (PACK_BITS) begin
            tx_data <= {tx_data[RGB_SIZE-2:0], ram_rd_data[RGB_SIZE-1]};
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            tx_data <= ram_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
